// File: rtl/sync_fifo_pf.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, read strobe and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered-read mode.
module sync_fifo_pf #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH_LEN = 4,
    parameter int unsigned AFULL_TH  = 12,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic                 i_clr_err,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_valid,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_afull,
    output logic                 o_aempty,
    output logic [DEPTH_LEN:0]   o_count,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LEN;
    localparam int unsigned CW    = DEPTH_LEN + 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LEN-1:0] wr_ptr;
    logic [DEPTH_LEN-1:0] rd_ptr;
    logic [CW-1:0]        count;
    logic                 rd_acc_c;
    logic                 wr_acc_c;

    // A full FIFO still accepts a write when the same edge frees a slot.
    assign rd_acc_c = rd_en && !o_empty;
    assign wr_acc_c = wr_en && (!o_full || rd_acc_c);

    assign o_count  = count;
    assign o_empty  = (count == CW'(0));
    assign o_full   = (count == CW'(DEPTH));
    assign o_afull  = (count >= CW'(AFULL_TH));
    assign o_aempty = (count <= CW'(AEMPTY_TH));

    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_acc_c) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + DEPTH_LEN'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + DEPTH_LEN'(1);
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= (wr_en && !wr_acc_c) || (o_overflow && !i_clr_err);
            o_underflow <= (rd_en && !rd_acc_c) || (o_underflow && !i_clr_err);
        end
    end

`ifdef FIFO_FWFT_EN
    assign o_data  = mem[rd_ptr];
    assign o_valid = !o_empty;
`else
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= rd_acc_c;
            if (rd_acc_c) begin
                o_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_pf.sv
// Scoreboard bench for sync_fifo_pf: directed scenarios plus randomized traffic vs a queue model.
module tb_sync_fifo_pf;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DLEN  = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFTH  = 12;
    localparam int unsigned AETH  = 2;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [WIDTH-1:0] i_data = '0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic             i_clr_err = 1'b0;
    logic [WIDTH-1:0] o_data;
    logic             o_valid, o_full, o_empty, o_afull, o_aempty;
    logic [DLEN:0]    o_count;
    logic             o_overflow, o_underflow;

    sync_fifo_pf #(.WIDTH(WIDTH), .DEPTH_LEN(DLEN), .AFULL_TH(AFTH), .AEMPTY_TH(AETH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .wr_en(wr_en), .rd_en(rd_en),
        .i_clr_err(i_clr_err), .o_data(o_data), .o_valid(o_valid), .o_full(o_full),
        .o_empty(o_empty), .o_afull(o_afull), .o_aempty(o_aempty), .o_count(o_count),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: FIFO contents, words read out awaiting the monitor, error flags.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf = 1'b0, m_udf = 1'b0, m_valid = 1'b0;
    logic [WIDTH-1:0] m_last = '0;
    bit               mon_en = 1'b0;
    int               n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d,
                        input logic clr, input logic rst);
        logic ra, wa;
        logic [WIDTH-1:0] v;
        @(negedge i_clk);
        wr_en = w; rd_en = r; i_data = d; i_clr_err = clr; i_rst_n = !rst;
        ra = !rst && r && (q.size() != 0);
        wa = !rst && w && ((q.size() < DEPTH) || ra);
        @(posedge i_clk);
        if (rst) begin
            q.delete(); exp_q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_last = '0;
        end else begin
            if (ra) begin
                v = q.pop_front();
                exp_q.push_back(v);
                m_last = v;
            end
            if (wa) q.push_back(d);
            m_valid = ra;
            m_ovf = (w && !wa) || (m_ovf && !clr);
            m_udf = (r && !ra) || (m_udf && !clr);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on each presented word.
    initial begin
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                chk("count",   WIDTH'(o_count),     WIDTH'(q.size()));
                chk("empty",   WIDTH'(o_empty),     WIDTH'(q.size() == 0));
                chk("full",    WIDTH'(o_full),      WIDTH'(q.size() == DEPTH));
                chk("afull",   WIDTH'(o_afull),     WIDTH'(q.size() >= AFTH));
                chk("aempty",  WIDTH'(o_aempty),    WIDTH'(q.size() <= AETH));
                chk("ovf",     WIDTH'(o_overflow),  WIDTH'(m_ovf));
                chk("udf",     WIDTH'(o_underflow), WIDTH'(m_udf));
`ifdef FIFO_FWFT_EN
                chk("valid", WIDTH'(o_valid), WIDTH'(q.size() != 0));
                if (o_valid && q.size() != 0) chk("head", o_data, q[0]);
                exp_q.delete();
`else
                chk("valid", WIDTH'(o_valid), WIDTH'(m_valid));
                if (o_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", o_data, ~o_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", o_data, e);
                    end
                end else begin
                    chk("hold", o_data, m_last);
                end
`endif
            end
        end
    end

    initial begin
        int wp, rp;
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        mon_en = 1'b1;
        idle();

        // Fill to full, then one overflowing write.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hAA, 1'b0, 1'b0);
        idle();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Drain, then underflow on empty and clear.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        idle();
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        idle();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Full with simultaneous read and write.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        idle();

        // Empty with simultaneous read and write.
        step(1'b1, 1'b1, 32'h33, 1'b0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b1, 1'b0);
        idle();

        // Mid-operation reset discards contents.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(32'h100 + i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        idle();

        // Randomized traffic with phases biased toward full and empty.
        for (int i = 0; i < 3000; i++) begin
            wp = ((i / 150) % 2 == 0) ? 80 : 25;
            rp = ((i / 150) % 2 == 0) ? 30 : 75;
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
        end
        idle();
        idle();
        mon_en = 1'b0;
        chk("scoreboard_drained", WIDTH'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
